flop_skid: RTL and testbench
============================

// Module: flop_skid
// PURPOSE
//  Elastic pipeline register: the backpressure-aware counterpart of the plain flop stages.
//  - Data flows forward; a ready signal flows backward, so a DSP stage can stall without dropping words.
//  - Two-entry buffer (main + skid) gives full 1 word/cycle throughput with no combinational in_ready<-out_ready path.
//  - Inserted between multiplier/adder pipeline stages whose consumer can stall.
// PARAMETERS
//  NN        16  data width in bits
//  STALL_CW  16  width of stall_count (only used with FLOP_SKID_STALL_CNT_EN)
// PORTS
//  clk          in   1         rising-edge clock
//  reset_n      in   1         asynchronous reset, active low
//  flush        in   1         synchronous clear of all buffered words
//  in_valid     in   1         producer has a word on in
//  in_ready     out  1         block accepts a word this cycle
//  in           in   NN        input data
//  out_valid    out  1         out holds a valid word
//  out_ready    in   1         consumer takes out this cycle
//  out          out  NN        output data, driven from the main register
//  stall_count  out  STALL_CW  count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States: EMPTY (no word), BUSY (main full), FULL (main+skid full).
//  - Output decode:
//    - out_valid = (state != EMPTY).
//    - in_ready = reset_n & (state != FULL); state-derived only, never from out_ready.
//  - Reset (async, reset_n low):
//    - state=EMPTY; main, skid and stall_count = 0.
//    - out_valid=0, out=0, in_ready=0 while reset_n is low; in_ready=1 from the first edge after release.
//    - Asserting reset mid-operation discards all buffered words immediately.
//  - State transitions:
//    - EMPTY: in_fire -> main<=in, BUSY.
//    - BUSY: in_fire&out_fire -> main<=in, stay BUSY.
//    - BUSY: in_fire only -> skid<=in, FULL.
//    - BUSY: out_fire only -> EMPTY.
//    - FULL: out_fire -> main<=skid, BUSY. No in_fire is possible in FULL.
//    - Any state, no fire -> hold.
//  - Latency: 1 cycle from in_fire (state EMPTY/BUSY) to out.
//  - Ordering: strict FIFO; no loss, no duplication.
//  - out_ready while out_valid=0 has no effect. in_valid while in_ready=0: word not taken; the producer holds it.
//  - flush: top priority. Next state EMPTY, stall_count<=0; any word offered in the same cycle is discarded.
//  - Data passes unmodified; no width change.
// CONFIGURATION
//  FLOP_SKID_STALL_CNT_EN defined:
//    - stall_count increments each cycle with out_valid & !out_ready.
//    - Saturates at all-ones; cleared by reset_n or flush.
//  Undefined: stall_count tied to 0; no counter logic.
// STRUCTURE
//  - Package flop_pkg: typedef enum logic [1:0] {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10} skid_state_t.
//  - Sub-module flop_en: NN-bit register, load enable, async active-low reset to 0.
//    Instantiated twice (main, skid).
//  - FSM and stall counter live in flop_skid.
// TESTING
//  1. Reset mid-stream in FULL:
//     - reset_n low -> out_valid=0, out=0, in_ready=0, stall_count=0.
//     - Release -> in_ready=1 after the next edge.
//  2. Streaming, out_ready=1, in_valid=1, words 0x0001..0x0008:
//     - Same words on out one cycle later, consecutive.
//     - in_ready stays 1 throughout.
//  3. Backpressure, out_ready=0, push 0xA5A5, 0x5A5A:
//     - FULL; in_ready=0; 0x1234 is held by the producer.
//     - out_ready=1 -> out 0xA5A5, 0x5A5A, 0x1234 in order.
//  4. flush in FULL with in_valid=1, in=0xBEEF:
//     - Next cycle out_valid=0, in_ready=1; 0xBEEF never appears.
//  5. Macro defined, out_valid=1, out_ready=0 for 10 cycles:
//     - stall_count=10.
//     - With STALL_CW=3 it saturates at 7.
//     - Macro undefined: stall_count=0.
//  6. Random in_valid/out_ready, 10k cycles, scoreboard:
//     - Output sequence equals input sequence.
//     - in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/flop_pkg.sv
// Shared types for the elastic skid register.
// Occupancy states of the two-entry main/skid buffer.
package flop_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/flop_skid_if.sv
// Valid/ready bundle for flop_skid: producer side (in) and consumer side (out).
// master drives words in and takes them out; slave is the skid register.
interface flop_skid_if #(
    parameter int NN = 16
);

    logic          in_valid;
    logic          in_ready;
    logic [NN-1:0] in;
    logic          out_valid;
    logic          out_ready;
    logic [NN-1:0] out;

    modport master (
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out
    );

endinterface

// File: rtl/flop_en.sv
// NN-bit load-enable register with asynchronous active-low clear.
// Used for both the main and the skid slot of flop_skid.
module flop_en #(
    parameter int NN = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [NN-1:0] d,
    output logic [NN-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/flop_skid.sv
// Two-entry elastic pipeline register (main + skid), full throughput.
// Optional stall counter: define FLOP_SKID_STALL_CNT_EN to enable it.
module flop_skid
    import flop_pkg::*;
#(
    parameter int NN       = 16,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    flop_skid_if.slave          bus,
    output logic [STALL_CW-1:0] stall_count
);

    skid_state_t   state;
    logic          ready_q;
    logic          in_fire;
    logic          out_fire;
    logic          main_en;
    logic          skid_en;
    logic [NN-1:0] main_d;
    logic [NN-1:0] main_q;
    logic [NN-1:0] skid_q;

    // in_ready is a pure function of registered state, never of out_ready.
    assign bus.out_valid = (state != EMPTY);
    assign bus.in_ready  = reset_n & ready_q & (state != FULL);
    assign bus.out       = main_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in;
        if (!flush) begin
            unique case (1'b1)
                state == EMPTY: begin
                    main_en = in_fire;
                end
                state == BUSY: begin
                    main_en = in_fire & out_fire;
                    skid_en = in_fire & ~out_fire;
                end
                state == FULL: begin
                    main_en = out_fire;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (in_fire) state <= BUSY;
                    BUSY: begin
                        if (in_fire && !out_fire) begin
                            state <= FULL;
                        end else if (out_fire && !in_fire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL:    if (out_fire) state <= BUSY;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    flop_en #(.NN(NN)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (main_en),
        .d       (main_d),
        .q       (main_q)
    );

    flop_en #(.NN(NN)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (skid_en),
        .d       (bus.in),
        .q       (skid_q)
    );

`ifdef FLOP_SKID_STALL_CNT_EN
    logic [STALL_CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_count = cnt;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_flop_skid.sv
// Self-checking bench for flop_skid: directed scenarios plus a random
// occupancy/queue reference model.
module tb_flop_skid;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush   = 1'b0;
    logic [15:0] stall;
    logic [2:0]  stall_s;
    int          tests   = 0;
    int          fails   = 0;

    flop_skid_if #(.NN(16)) bus ();
    flop_skid_if #(.NN(16)) bus_s ();

    // Second instance mirrors the stimulus to observe a 3-bit counter.
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in        = bus.in;
    assign bus_s.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    flop_skid #(.NN(16), .STALL_CW(16)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus.slave),
        .stall_count (stall)
    );

    flop_skid #(.NN(16), .STALL_CW(3)) u_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus_s.slave),
        .stall_count (stall_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0
            || bus.in_ready !== 1'b0 || stall !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: vld=%b out=%h rdy=%b stall=%0d want 0/0/0/0",
                     bus.out_valid, bus.out, bus.in_ready, stall);
        end
        tick();
        reset_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: rdy=%b want 0", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_edge: rdy=%b vld=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 16'h1111;
        tick();
        bus.in        = 16'h2222;
        tick();
        bus.in_valid  = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out !== 16'h1111) begin
            fails++;
            $display("FAIL full_before_reset: rdy=%b out=%h want 0/1111",
                     bus.in_ready, bus.out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0
            || bus.in_ready !== 1'b0 || stall !== 16'h0) begin
            fails++;
            $display("FAIL midreset: vld=%b out=%h rdy=%b stall=%0d want 0/0/0/0",
                     bus.out_valid, bus.out, bus.in_ready, stall);
        end
        tick();
        reset_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset_release: rdy=%b want 0", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after: rdy=%b vld=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 16'(i);
            tests++;
            if (bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready[%0d]: rdy=%b want 1", i, bus.in_ready);
            end
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out !== 16'(i)) begin
                fails++;
                $display("FAIL stream_out[%0d]: vld=%b out=%h want 1/%h",
                         i, bus.out_valid, bus.out, 16'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: vld=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 16'hA5A5;
        tick();
        bus.in        = 16'h5A5A;
        tick();
        bus.in        = 16'h1234;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out !== 16'hA5A5) begin
            fails++;
            $display("FAIL bp_full: rdy=%b out=%h want 0/a5a5", bus.in_ready, bus.out);
        end
        tick();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out !== 16'hA5A5 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: rdy=%b vld=%b out=%h want 0/1/a5a5",
                     bus.in_ready, bus.out_valid, bus.out);
        end
        bus.out_ready = 1'b1;
        tick();
        tests++;
        if (bus.out !== 16'h5A5A || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_second: out=%h rdy=%b want 5a5a/1", bus.out, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out !== 16'h1234 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_third: out=%h vld=%b want 1234/1", bus.out, bus.out_valid);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: vld=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 16'h0101;
        tick();
        bus.in        = 16'h0202;
        tick();
        bus.in        = 16'hBEEF;
        flush         = 1'b1;
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state: vld=%b rdy=%b want 0/1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_leak[%0d]: vld=%b out=%h want 0",
                         i, bus.out_valid, bus.out);
            end
        end
    endtask

    task automatic test_stall_count();
        logic [15:0] exp_w;
        logic [2:0]  exp_s;
`ifdef FLOP_SKID_STALL_CNT_EN
        exp_w = 16'd10;
        exp_s = 3'd7;
`else
        exp_w = 16'd0;
        exp_s = 3'd0;
`endif
        flush        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        flush        = 1'b0;
        tests++;
        if (stall !== 16'h0 || stall_s !== 3'h0) begin
            fails++;
            $display("FAIL stall_clear: cnt=%0d sat=%0d want 0/0", stall, stall_s);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 16'h7777;
        tick();
        bus.in_valid  = 1'b0;
        repeat (10) tick();
        tests++;
        if (stall !== exp_w) begin
            fails++;
            $display("FAIL stall_count: cnt=%0d want %0d", stall, exp_w);
        end
        tests++;
        if (stall_s !== exp_s) begin
            fails++;
            $display("FAIL stall_sat: cnt=%0d want %0d", stall_s, exp_s);
        end
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic        r0;
        logic        ofire;
        logic        ifire;
        logic [15:0] w;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in       = 16'($urandom);
            r0           = bus.in_ready;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (bus.in_ready !== r0 || bus.in_ready !== (q.size() < 2)) begin
                fails++;
                $display("FAIL rnd_ready[%0d]: rdy=%b before=%b want %b",
                         c, bus.in_ready, r0, q.size() < 2);
            end
            tests++;
            if (bus.out_valid !== (q.size() != 0)) begin
                fails++;
                $display("FAIL rnd_valid[%0d]: vld=%b want %b",
                         c, bus.out_valid, q.size() != 0);
            end
            ofire = (q.size() != 0) && bus.out_ready;
            ifire = (q.size() < 2) && bus.in_valid;
            if (ofire) begin
                w = q.pop_front();
                tests++;
                if (bus.out !== w) begin
                    fails++;
                    $display("FAIL rnd_data[%0d]: out=%h want %h", c, bus.out, w);
                end
            end
            if (ifire) q.push_back(bus.in);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_full();
        test_backpressure();
        test_flush();
        test_stall_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
